// File: rtl/corvus_mmio_pkg.sv
// rtl/corvus_mmio_pkg.sv - shared memory-map constants for the corvus MMIO blocks
package corvus_mmio_pkg;

  // CPU-visible register width of every MMIO block
  localparam int GPIO_REG_W = 16;

  // GPIO register indices, shared by the address decoder and firmware headers
  typedef enum logic [2:0] {
    GPIO_DATA   = 3'd0,
    GPIO_DIR    = 3'd1,
    GPIO_SET    = 3'd2,
    GPIO_CLR    = 3'd3,
    GPIO_IEN    = 3'd4,
    GPIO_RISE   = 3'd5,
    GPIO_FALL   = 3'd6,
    GPIO_STATUS = 3'd7
  } gpioReg_e;

endpackage

// File: rtl/gpio_sync.sv
// rtl/gpio_sync.sv - pad input synchroniser plus one history flop for edge detection
module gpio_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] pinsAsync,
  output logic [WIDTH-1:0] syncOut,
  output logic [WIDTH-1:0] histOut
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  // Shift the raw pads through the synchroniser, then keep one extra sample of history
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
      histOut <= '0;
    end else begin
      stage[0] <= pinsAsync;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
      histOut <= stage[SYNC_STAGES-1];
    end
  end

  assign syncOut = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - memory-mapped GPIO bank with edge-triggered interrupt status
module gpio_bank #(
  parameter int          WIDTH       = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] RESET_DIR   = 16'h0000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sel,
  input  logic             write,
  input  logic [2:0]       addr,
  input  logic [15:0]      din,
  output logic [15:0]      dout,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] pins_out,
  output logic [WIDTH-1:0] pins_oe,
  output logic             irq
);

  import corvus_mmio_pkg::*;

  logic [WIDTH-1:0] outReg;
  logic [WIDTH-1:0] dirReg;
  logic [WIDTH-1:0] ienReg;
  logic [WIDTH-1:0] riseReg;
  logic [WIDTH-1:0] fallReg;
  logic [WIDTH-1:0] statusReg;

  logic [WIDTH-1:0] syncIn;
  logic [WIDTH-1:0] histIn;
  logic [WIDTH-1:0] riseEdge;
  logic [WIDTH-1:0] fallEdge;
  logic [WIDTH-1:0] eventBits;
  logic [WIDTH-1:0] wrData;
  logic [WIDTH-1:0] w1cMask;
  logic [WIDTH-1:0] rdNarrow;
  logic [GPIO_REG_W-1:0] readData;

  logic rdStrobe;
  logic wrStrobe;

  // Bits above WIDTH of the CPU bus are simply never stored
  assign rdStrobe = sel & ~write;
  assign wrStrobe = sel & write;
  assign wrData   = din[WIDTH-1:0];

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK       (CLK),
    .RST       (RST),
    .pinsAsync (pins_in),
    .syncOut   (syncIn),
    .histOut   (histIn)
  );

  // Edge events come from flopped samples only, so pins never reach an output combinationally
  always_comb begin
    riseEdge  = syncIn & ~histIn;
    fallEdge  = ~syncIn & histIn;
    eventBits = (riseEdge & riseReg) | (fallEdge & fallReg);
  end

  // Control registers; reset wins over any access on the same edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      outReg  <= '0;
      dirReg  <= RESET_DIR[WIDTH-1:0];
      ienReg  <= '0;
      riseReg <= '0;
      fallReg <= '0;
    end else if (wrStrobe) begin
      case (addr)
        GPIO_DATA: outReg  <= wrData;
        GPIO_DIR:  dirReg  <= wrData;
        GPIO_SET:  outReg  <= outReg | wrData;
        GPIO_CLR:  outReg  <= outReg & ~wrData;
        GPIO_IEN:  ienReg  <= wrData;
        GPIO_RISE: riseReg <= wrData;
        GPIO_FALL: fallReg <= wrData;
        default:   ;
      endcase
    end
  end

  // Write-1-to-clear mask for STATUS, only during a STATUS write
  always_comb begin
    w1cMask = '0;
    if (wrStrobe && (addr == GPIO_STATUS)) begin
      w1cMask = wrData;
    end
  end

  // STATUS latches events regardless of IEN; a new event beats a same-cycle clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      statusReg <= '0;
    end else begin
      statusReg <= (statusReg & ~w1cMask) | eventBits;
    end
  end

  // Interrupt is a registered OR of the enabled status bits
  always_ff @(posedge CLK) begin
    if (RST) begin
      irq <= 1'b0;
    end else begin
      irq <= |(statusReg & ienReg);
    end
  end

  // Read mux; DATA shows the driven value on outputs and the synchronised pad on inputs
  always_comb begin
    rdNarrow = '0;
    case (addr)
      GPIO_DATA:   rdNarrow = (dirReg & outReg) | (~dirReg & syncIn);
      GPIO_DIR:    rdNarrow = dirReg;
      GPIO_IEN:    rdNarrow = ienReg;
      GPIO_RISE:   rdNarrow = riseReg;
      GPIO_FALL:   rdNarrow = fallReg;
      GPIO_STATUS: rdNarrow = statusReg;
      default:     rdNarrow = '0;
    endcase
    readData = '0;
    readData[WIDTH-1:0] = rdNarrow;
  end

  // Read data register; holds between reads and across writes
  always_ff @(posedge CLK) begin
    if (RST) begin
      dout <= '0;
    end else if (rdStrobe) begin
      dout <= readData;
    end
  end

  assign pins_out = outReg;
  assign pins_oe  = dirReg;

endmodule
